conv_frame_ctrl: RTL

Frame sequencer for the streaming 3x3 convolution datapath. Accepts one pixel per handshake from an upstream valid/ready stream, drives the datapath's advance enable and clear, tracks row/column position, and emits only the fully covered window results on a downstream valid/ready stream. It sits between the image source and the `conv` pipeline, which it stalls as a unit under backpressure.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_pos_cnt.sv | 41 ++++
 rtl/conv_frame_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults, state codes and derived sizes for the conv frame sequencer
package conv_pkg;

  localparam int N_DEF = 5;
  localparam int M_DEF = 5;
  localparam int K_DEF = 3;

  localparam int COL_W = $clog2(N_DEF);
  localparam int ROW_W = $clog2(M_DEF);

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CLR   = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_FLUSH = 2'd3;

  // Number of fully covered KxK windows in an MxN image.
  function automatic int out_per_frame(input int n, input int m, input int k);
    return (n - k + 1) * (m - k + 1);
  endfunction

  localparam int OUT_PER_FRAME = out_per_frame(N_DEF, M_DEF, K_DEF);

endpackage

// File: rtl/conv_pos_cnt.sv
// rtl/conv_pos_cnt.sv - row/column position counter with wrap, enable and clear
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int K  = K_DEF,
  parameter int CW = COL_W,
  parameter int RW = ROW_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          win_ok,
  output logic          frame_end
);

  assign win_ok    = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign frame_end = (row == RW'(M - 1)) && (col == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == CW'(N - 1)) begin
        col <= '0;
        row <= (row == RW'(M - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - frame sequencer for the 3x3 conv datapath; CONV_FRAME_CTRL_STATS_EN adds frame/stall counters
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int K  = K_DEF,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          adv,
  output logic [DW-1:0] pix,
  output logic          conv_clr,
  input  logic [OW-1:0] conv_pxl,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last
`ifdef CONV_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int OPF = out_per_frame(N, M, K);
  localparam int OCW = $clog2(OPF + 1);
  localparam int CW  = $clog2(N);
  localparam int RW  = $clog2(M);

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic           win_ok;
  logic           frame_end;
  logic [OCW-1:0] out_cnt;
  logic           hs;

  assign busy     = (state != S_IDLE);
  assign conv_clr = (state == S_CLR);
  assign s_ready  = (state == S_RUN) && (!m_valid || m_ready);
  assign adv      = s_valid && s_ready;
  assign pix      = s_data;
  assign m_data   = conv_pxl;
  assign hs       = m_valid && m_ready;

  conv_pos_cnt #(.N(N), .M(M), .K(K), .CW(CW), .RW(RW)) u_pos (
    .clk       (clk),
    .reset     (reset),
    .clr       (conv_clr),
    .en        (adv),
    .row       (row),
    .col       (col),
    .win_ok    (win_ok),
    .frame_end (frame_end)
  );

  // A start arriving while done is still high is dropped; it must be held to count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:  if (start && !done) state <= S_CLR;
        S_CLR:   state <= S_RUN;
        S_RUN:   if (adv && frame_end) state <= S_FLUSH;
        S_FLUSH: if (hs) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // adv implies the held result is gone, so an accepted pixel always rewrites m_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      out_cnt <= '0;
    end else if (conv_clr) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      out_cnt <= '0;
    end else if (adv) begin
      m_valid <= win_ok;
      m_last  <= win_ok && (out_cnt == OCW'(OPF - 1));
      if (win_ok) out_cnt <= out_cnt + 1'b1;
    end else if (hs) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

`ifdef CONV_FRAME_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (done) frame_cnt <= frame_cnt + 1'b1;
      if (conv_clr) begin
        stall_cnt <= '0;
      end else if ((state == S_RUN || state == S_FLUSH) && m_valid && !m_ready
                   && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
